icache_assoc: RTL and testbench

Parametrised N-way set-associative instruction cache, the successor to the direct-mapped fetch cache. It sits between the fetch stage and the L2 and serves one word per cycle on hits. It handles misses with a single outstanding line fill, uses invalid-first / round-robin replacement, and supports a whole-cache flush walk.

---
 rtl/icache_assoc_if.sv | 52 +++++
 rtl/icache_assoc.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_icache_assoc.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_assoc_if.sv
// ----------------------------------------------------------------------------
// icache_assoc_if
// Bundles the fetch-side and L2-side signals of icache_assoc.
//   slave  : cache side (drives CACHE_READY, DATA*, ADDR_OUT, ADDR_TO_L2*)
//   master : fetch stage / L2 side (drives FLUSH, ADDR*, DATA_FROM_L2*)
// Optional macro ICACHE_PERF_EN adds HIT_COUNT / MISS_COUNT (cache outputs).
// ----------------------------------------------------------------------------
interface icache_assoc_if #(
    parameter int data_width    = 32,
    parameter int address_width = 32,
    parameter int block_size    = 8
);
    localparam int offset_width = $clog2(block_size * data_width / 8);
    localparam int line_width   = block_size * data_width;

    logic                                  FLUSH;
    logic [address_width-1:0]              ADDR;
    logic                                  ADDR_VALID;
    logic                                  CACHE_READY;
    logic [data_width-1:0]                 DATA;
    logic                                  DATA_VALID;
    logic [address_width-1:0]              ADDR_OUT;
    logic                                  ADDR_TO_L2_VALID;
    logic [address_width-offset_width-1:0] ADDR_TO_L2;
    logic [line_width-1:0]                 DATA_FROM_L2;
    logic                                  DATA_FROM_L2_VALID;

`ifdef ICACHE_PERF_EN
    logic [31:0]                           HIT_COUNT;
    logic [31:0]                           MISS_COUNT;

    modport slave (
        input  FLUSH, ADDR, ADDR_VALID, DATA_FROM_L2, DATA_FROM_L2_VALID,
        output CACHE_READY, DATA, DATA_VALID, ADDR_OUT, ADDR_TO_L2_VALID, ADDR_TO_L2,
        output HIT_COUNT, MISS_COUNT
    );
    modport master (
        output FLUSH, ADDR, ADDR_VALID, DATA_FROM_L2, DATA_FROM_L2_VALID,
        input  CACHE_READY, DATA, DATA_VALID, ADDR_OUT, ADDR_TO_L2_VALID, ADDR_TO_L2,
        input  HIT_COUNT, MISS_COUNT
    );
`else
    modport slave (
        input  FLUSH, ADDR, ADDR_VALID, DATA_FROM_L2, DATA_FROM_L2_VALID,
        output CACHE_READY, DATA, DATA_VALID, ADDR_OUT, ADDR_TO_L2_VALID, ADDR_TO_L2
    );
    modport master (
        output FLUSH, ADDR, ADDR_VALID, DATA_FROM_L2, DATA_FROM_L2_VALID,
        input  CACHE_READY, DATA, DATA_VALID, ADDR_OUT, ADDR_TO_L2_VALID, ADDR_TO_L2
    );
`endif
endinterface

// File: rtl/icache_assoc.sv
// ----------------------------------------------------------------------------
// icache_assoc
// N-way set-associative instruction cache. One word per cycle on hits, a
// single outstanding line fill on misses, invalid-first / round-robin
// replacement and a one-set-per-cycle flush walk.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-low reset
//   bus  : icache_assoc_if.slave (fetch request/response, L2 line request/fill)
// Optional feature: define ICACHE_PERF_EN to add HIT_COUNT / MISS_COUNT.
// ----------------------------------------------------------------------------
module icache_assoc #(
    parameter int                       data_width    = 32,
    parameter int                       address_width = 32,
    parameter int                       block_size    = 8,
    parameter int                       sets          = 128,
    parameter int                       ways          = 2,
    parameter logic [address_width-1:0] addr_init_val = '0
) (
    input  logic          CLK,
    input  logic          RST,
    icache_assoc_if.slave bus
);
    localparam int byte_bits    = $clog2(data_width / 8);
    localparam int offset_width = $clog2(block_size * data_width / 8);
    localparam int index_width  = $clog2(sets);
    localparam int tag_width    = address_width - index_width - offset_width;
    localparam int line_width   = block_size * data_width;
    localparam int word_sel_w   = offset_width - byte_bits;
    localparam int way_w        = (ways > 1) ? $clog2(ways) : 1;

    typedef enum logic [2:0] {
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        REPLAY,
        FLUSH_WALK
    } state_t;

    state_t                             state_q, state_d;
    logic                               req_valid_q, req_valid_d;
    logic [address_width-1:0]           addr_out_q, addr_out_d;
    logic [way_w-1:0]                   victim_q, victim_d;
    logic                               victim_was_valid_q, victim_was_valid_d;
    logic [line_width-1:0]              fill_line_q, fill_line_d;
    logic                               flush_pend_q, flush_pend_d;
    logic                               replay_q, replay_d;
    logic [index_width-1:0]             walk_idx_q, walk_idx_d;
    logic [sets-1:0][ways-1:0]          valid_q, valid_d;
    logic [sets-1:0][way_w-1:0]         ptr_q, ptr_d;

    logic [index_width-1:0]             req_idx;
    logic [tag_width-1:0]               req_tag;
    logic [word_sel_w-1:0]              req_word;
    logic [index_width-1:0]             rd_idx;
    logic                               mem_wr;
    logic [ways-1:0][tag_width-1:0]     rd_tag;
    logic [ways-1:0][line_width-1:0]    rd_line;
    logic [ways-1:0]                    way_match;
    logic                               hit_one;
    logic                               lookup_miss;
    logic                               data_valid;
    logic                               cache_ready;
    logic                               l2_req;
    logic [line_width-1:0]              sel_line;
    logic [block_size-1:0][data_width-1:0] sel_words;
    logic [way_w-1:0]                   pick_way;
    logic                               pick_valid;
    logic                               unused_bits;

    assign req_idx  = addr_out_q[offset_width +: index_width];
    assign req_tag  = addr_out_q[address_width-1 -: tag_width];
    assign req_word = addr_out_q[byte_bits +: word_sel_w];
    assign unused_bits = ^addr_out_q[byte_bits-1:0];

    function automatic logic [way_w-1:0] ptr_next(input logic [way_w-1:0] p);
        return (p == way_w'(ways - 1)) ? '0 : p + 1'b1;
    endfunction

    // Per-way tag and data RAMs: registered read address, written only in FILL.
    genvar gi;
    generate
        for (gi = 0; gi < ways; gi++) begin : g_way
            logic [tag_width-1:0]  tag_mem  [sets];
            logic [line_width-1:0] data_mem [sets];
            logic [tag_width-1:0]  tag_rd_q;
            logic [line_width-1:0] data_rd_q;

            always_ff @(posedge CLK) begin
                if (mem_wr && (victim_q == way_w'(gi))) begin
                    tag_mem[req_idx]  <= req_tag;
                    data_mem[req_idx] <= fill_line_q;
                end
                tag_rd_q  <= tag_mem[rd_idx];
                data_rd_q <= data_mem[rd_idx];
            end

            assign rd_tag[gi]    = tag_rd_q;
            assign rd_line[gi]   = data_rd_q;
            assign way_match[gi] = valid_q[req_idx][gi] && (rd_tag[gi] == req_tag);
        end
    endgenerate

    // A hit needs exactly one matching valid way.
    assign hit_one     = (way_match != '0) && ((way_match & (way_match - 1'b1)) == '0);
    assign lookup_miss = (state_q == LOOKUP) && req_valid_q && !hit_one;
    assign data_valid  = (state_q == LOOKUP) && req_valid_q && hit_one;

    always_comb begin
        sel_line = '0;
        for (int w = 0; w < ways; w++) begin
            if (way_match[w]) begin
                sel_line = sel_line | rd_line[w];
            end
        end
    end
    assign sel_words = sel_line;

    // Lowest-indexed invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        pick_way   = ptr_q[req_idx];
        pick_valid = 1'b1;
        for (int w = ways - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                pick_way   = way_w'(w);
                pick_valid = 1'b0;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        req_valid_d        = req_valid_q;
        addr_out_d         = addr_out_q;
        victim_d           = victim_q;
        victim_was_valid_d = victim_was_valid_q;
        fill_line_d        = fill_line_q;
        flush_pend_d       = flush_pend_q;
        replay_d           = 1'b0;
        walk_idx_d         = walk_idx_q;
        valid_d            = valid_q;
        ptr_d              = ptr_q;
        rd_idx             = req_idx;
        cache_ready        = 1'b0;
        l2_req             = 1'b0;
        mem_wr             = 1'b0;

        case (state_q)
            LOOKUP: begin
                cache_ready = !lookup_miss;
                rd_idx      = bus.ADDR[offset_width +: index_width];
                if (lookup_miss) begin
                    state_d            = MISS_REQ;
                    victim_d           = pick_way;
                    victim_was_valid_d = pick_valid;
                    if (bus.FLUSH) begin
                        flush_pend_d = 1'b1;
                    end
                end else if (bus.FLUSH) begin
                    // Current compare finishes this cycle; any new request is dropped.
                    state_d     = FLUSH_WALK;
                    req_valid_d = 1'b0;
                    walk_idx_d  = '0;
                end else begin
                    req_valid_d = bus.ADDR_VALID;
                    if (bus.ADDR_VALID) begin
                        addr_out_d = bus.ADDR;
                    end
                end
            end
            MISS_REQ: begin
                l2_req  = 1'b1;
                state_d = MISS_WAIT;
                if (bus.FLUSH) begin
                    flush_pend_d = 1'b1;
                end
            end
            MISS_WAIT: begin
                if (bus.FLUSH) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.DATA_FROM_L2_VALID) begin
                    fill_line_d = bus.DATA_FROM_L2;
                    state_d     = FILL;
                end
            end
            FILL: begin
                mem_wr                     = 1'b1;
                valid_d[req_idx][victim_q] = 1'b1;
                if (victim_was_valid_q) begin
                    ptr_d[req_idx] = ptr_next(ptr_q[req_idx]);
                end
                if (flush_pend_q || bus.FLUSH) begin
                    state_d      = FLUSH_WALK;
                    req_valid_d  = 1'b0;
                    flush_pend_d = 1'b0;
                    walk_idx_d   = '0;
                end else begin
                    state_d = REPLAY;
                end
            end
            REPLAY: begin
                // rd_idx defaults to the pending request's set: re-read it.
                if (flush_pend_q || bus.FLUSH) begin
                    state_d      = FLUSH_WALK;
                    req_valid_d  = 1'b0;
                    flush_pend_d = 1'b0;
                    walk_idx_d   = '0;
                end else begin
                    state_d  = LOOKUP;
                    replay_d = 1'b1;
                end
            end
            FLUSH_WALK: begin
                valid_d[walk_idx_q] = '0;
                ptr_d[walk_idx_q]   = '0;
                walk_idx_d          = walk_idx_q + 1'b1;
                if (walk_idx_q == index_width'(sets - 1)) begin
                    state_d = LOOKUP;
                end
            end
            default: begin
                state_d = LOOKUP;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q            <= LOOKUP;
            req_valid_q        <= 1'b0;
            addr_out_q         <= addr_init_val;
            victim_q           <= '0;
            victim_was_valid_q <= 1'b0;
            fill_line_q        <= '0;
            flush_pend_q       <= 1'b0;
            replay_q           <= 1'b0;
            walk_idx_q         <= '0;
            valid_q            <= '0;
            ptr_q              <= '0;
        end else begin
            state_q            <= state_d;
            req_valid_q        <= req_valid_d;
            addr_out_q         <= addr_out_d;
            victim_q           <= victim_d;
            victim_was_valid_q <= victim_was_valid_d;
            fill_line_q        <= fill_line_d;
            flush_pend_q       <= flush_pend_d;
            replay_q           <= replay_d;
            walk_idx_q         <= walk_idx_d;
            valid_q            <= valid_d;
            ptr_q              <= ptr_d;
        end
    end

    assign bus.CACHE_READY      = cache_ready;
    assign bus.DATA_VALID       = data_valid;
    assign bus.DATA             = data_valid ? sel_words[req_word] : '0;
    assign bus.ADDR_OUT         = addr_out_q;
    assign bus.ADDR_TO_L2_VALID = l2_req;
    assign bus.ADDR_TO_L2       = l2_req ? addr_out_q[address_width-1:offset_width] : '0;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Hits delivered right after REPLAY belong to a miss already counted.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (data_valid && !replay_q) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (lookup_miss) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.HIT_COUNT  = hit_count_q;
    assign bus.MISS_COUNT = miss_count_q;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int BS   = 8;
    localparam int SETS = 128;
    localparam int WAYS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_assoc_if #(.data_width(DW), .address_width(AW), .block_size(BS)) bus ();

    icache_assoc #(
        .data_width(DW), .address_width(AW), .block_size(BS),
        .sets(SETS), .ways(WAYS), .addr_init_val(32'h0000_0000)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which line tags each set holds, with replacement rules.
    bit          m_valid [SETS][WAYS];
    logic [19:0] m_tag   [SETS][WAYS];
    int          m_ptr   [SETS];
    int unsigned m_hits;
    int unsigned m_misses;

    function automatic logic [31:0] line_word(input logic [31:0] line, input logic [31:0] k);
        return 32'hA000_0000 + ((line - 32'd8) << 4) + k;
    endfunction

    function automatic logic [255:0] fill_line(input logic [31:0] line);
        logic [255:0] v;
        for (int k = 0; k < BS; k++) v[k*32 +: 32] = line_word(line, k);
        return v;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_hits = 0;
        m_misses = 0;
    endfunction

    function automatic void m_flush();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    // Returns 1 when the access should hit; installs the line on a miss.
    function automatic bit m_access(input logic [31:0] a);
        int s;
        int victim;
        s = int'(a[11:5]);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:12]) begin
                m_hits++;
                return 1'b1;
            end
        m_misses++;
        victim = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) victim = w;
        if (victim < 0) begin
            victim = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        m_valid[s][victim] = 1'b1;
        m_tag[s][victim] = a[31:12];
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and serves its line fill; reports what was observed.
    task automatic fetch(input logic [31:0] a, input int lat,
                         output bit ok, output bit hit, output logic [31:0] data,
                         output bit ready_cmp, output logic [26:0] l2_addr,
                         output int l2_pulses, output int fill_lat);
        int n;
        ok = 1'b1; hit = 1'b0; data = '0; ready_cmp = 1'b0;
        l2_addr = '0; l2_pulses = 0; fill_lat = -1;
        n = 0;
        while (bus.CACHE_READY !== 1'b1 && n < 300) begin tick(); n++; end
        if (bus.CACHE_READY !== 1'b1) begin ok = 1'b0; return; end
        bus.ADDR = a;
        bus.ADDR_VALID = 1'b1;
        tick();
        bus.ADDR_VALID = 1'b0;
        ready_cmp = bus.CACHE_READY;
        if (bus.DATA_VALID === 1'b1) begin
            hit = 1'b1;
            data = bus.DATA;
            return;
        end
        n = 0;
        while (bus.ADDR_TO_L2_VALID !== 1'b1 && n < 20) begin tick(); n++; end
        if (bus.ADDR_TO_L2_VALID !== 1'b1) begin ok = 1'b0; return; end
        l2_addr = bus.ADDR_TO_L2;
        for (int i = 0; i < lat; i++) begin
            if (bus.ADDR_TO_L2_VALID === 1'b1) l2_pulses++;
            tick();
        end
        bus.DATA_FROM_L2 = fill_line({5'd0, l2_addr});
        bus.DATA_FROM_L2_VALID = 1'b1;
        tick();
        bus.DATA_FROM_L2_VALID = 1'b0;
        n = 1;
        while (bus.DATA_VALID !== 1'b1 && n < 10) begin tick(); n++; end
        if (bus.DATA_VALID !== 1'b1) begin ok = 1'b0; return; end
        fill_lat = n;
        data = bus.DATA;
    endtask

    task automatic test_reset();
        bus.FLUSH = 1'b0; bus.ADDR = '0; bus.ADDR_VALID = 1'b0;
        bus.DATA_FROM_L2 = '0; bus.DATA_FROM_L2_VALID = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        m_reset();
        n_cmp++; if (bus.CACHE_READY !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.CACHE_READY); end
        n_cmp++; if (bus.DATA_VALID !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b want 0", bus.DATA_VALID); end
        n_cmp++; if (bus.DATA !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.DATA); end
        n_cmp++; if (bus.ADDR_OUT !== 32'h0) begin n_err++; $display("FAIL reset_addr_out: got %h want 0", bus.ADDR_OUT); end
        n_cmp++; if (bus.ADDR_TO_L2_VALID !== 1'b0) begin n_err++; $display("FAIL reset_l2v: got %b want 0", bus.ADDR_TO_L2_VALID); end
        n_cmp++; if (bus.ADDR_TO_L2 !== 27'h0) begin n_err++; $display("FAIL reset_l2a: got %h want 0", bus.ADDR_TO_L2); end
`ifdef ICACHE_PERF_EN
        n_cmp++; if (bus.HIT_COUNT !== 32'h0) begin n_err++; $display("FAIL reset_hitcnt: got %0d want 0", bus.HIT_COUNT); end
        n_cmp++; if (bus.MISS_COUNT !== 32'h0) begin n_err++; $display("FAIL reset_misscnt: got %0d want 0", bus.MISS_COUNT); end
`endif
        $display("txn reset done");
    endtask

    task automatic test_first_miss();
        bit ok, hit, rc; logic [31:0] d; logic [26:0] la; int p, fl;
        void'(m_access(32'h100));
        fetch(32'h100, 2, ok, hit, d, rc, la, p, fl);
        $display("txn first_miss addr=00000100 hit=%0b data=%h l2=%h lat=%0d", hit, d, la, fl);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL first_ok: got %b want 1 (timeout)", ok); end
        n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL first_hit: got %b want 0", hit); end
        n_cmp++; if (rc !== 1'b0) begin n_err++; $display("FAIL first_ready_cmp: got %b want 0", rc); end
        n_cmp++; if (la !== 27'h8) begin n_err++; $display("FAIL first_l2addr: got %h want 8", la); end
        n_cmp++; if (p !== 1) begin n_err++; $display("FAIL first_l2pulse: got %0d want 1", p); end
        n_cmp++; if (fl !== 3) begin n_err++; $display("FAIL first_fill_lat: got %0d want 3", fl); end
        n_cmp++; if (d !== 32'hA000_0000) begin n_err++; $display("FAIL first_data: got %h want a0000000", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        bus.ADDR = 32'h104;
        bus.ADDR_VALID = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp = line_word(32'd8, k);
            void'(m_access(32'h100 + 4 * k));
            $display("txn b2b addr=%h dv=%b data=%h", 32'h100 + 4 * k, bus.DATA_VALID, bus.DATA);
            n_cmp++; if (bus.DATA_VALID !== 1'b1) begin n_err++; $display("FAIL b2b_dv%0d: got %b want 1", k, bus.DATA_VALID); end
            n_cmp++; if (bus.DATA !== exp) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", k, bus.DATA, exp); end
            n_cmp++; if (bus.CACHE_READY !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b want 1", k, bus.CACHE_READY); end
            if (k < 3) bus.ADDR = 32'h100 + 4 * (k + 1);
            else bus.ADDR_VALID = 1'b0;
        end
`ifdef ICACHE_PERF_EN
        n_cmp++; if (bus.MISS_COUNT !== 32'd1) begin n_err++; $display("FAIL perf_miss: got %0d want 1", bus.MISS_COUNT); end
        tick();
        n_cmp++; if (bus.HIT_COUNT !== 32'd3) begin n_err++; $display("FAIL perf_hit: got %0d want 3", bus.HIT_COUNT); end
`endif
    endtask

    task automatic test_replacement();
        logic [31:0] seq [5];
        bit ok, hit, rc, exp_hit; logic [31:0] d, a; logic [26:0] la; int p, fl;
        seq = '{32'h0000, 32'h1000, 32'h2000, 32'h1000, 32'h0000};
        for (int i = 0; i < 5; i++) begin
            a = seq[i];
            exp_hit = m_access(a);
            fetch(a, int'($urandom_range(2, 5)), ok, hit, d, rc, la, p, fl);
            $display("txn repl addr=%h hit=%0b data=%h", a, hit, d);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL repl_ok%0d: got %b want 1", i, ok); end
            n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL repl_hit%0d: got %b want %b", i, hit, exp_hit); end
            n_cmp++; if (d !== line_word(a >> 5, (a >> 2) & 7)) begin n_err++; $display("FAIL repl_data%0d: got %h want %h", i, d, line_word(a >> 5, (a >> 2) & 7)); end
        end
    endtask

    task automatic test_flush_miss();
        int n, lo; bit dv_seen, ok, hit, rc; logic [31:0] d; logic [26:0] la; int p, fl;
        n = 0;
        while (bus.CACHE_READY !== 1'b1 && n < 300) begin tick(); n++; end
        bus.ADDR = 32'h3000; bus.ADDR_VALID = 1'b1;
        tick();
        bus.ADDR_VALID = 1'b0;
        void'(m_access(32'h3000));
        n_cmp++; if (bus.CACHE_READY !== 1'b0) begin n_err++; $display("FAIL fl_cmp_ready: got %b want 0", bus.CACHE_READY); end
        tick();
        n_cmp++; if (bus.ADDR_TO_L2_VALID !== 1'b1) begin n_err++; $display("FAIL fl_l2v: got %b want 1", bus.ADDR_TO_L2_VALID); end
        tick();
        bus.FLUSH = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        bus.DATA_FROM_L2 = fill_line(32'h3000 >> 5);
        bus.DATA_FROM_L2_VALID = 1'b1;
        tick();
        bus.DATA_FROM_L2_VALID = 1'b0;
        dv_seen = (bus.DATA_VALID === 1'b1);
        tick();
        lo = 0; n = 0;
        while (bus.CACHE_READY === 1'b0 && n < 400) begin
            if (bus.DATA_VALID === 1'b1) dv_seen = 1'b1;
            lo++; tick(); n++;
        end
        m_flush();
        $display("txn flush_miss walk=%0d dv_seen=%0b", lo, dv_seen);
        n_cmp++; if (lo !== SETS) begin n_err++; $display("FAIL fl_walk_len: got %0d want %0d", lo, SETS); end
        n_cmp++; if (dv_seen !== 1'b0) begin n_err++; $display("FAIL fl_no_dv: got %b want 0", dv_seen); end
        void'(m_access(32'h100));
        fetch(32'h100, 3, ok, hit, d, rc, la, p, fl);
        $display("txn refetch addr=00000100 hit=%0b data=%h", hit, d);
        n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL fl_refetch_hit: got %b want 0", hit); end
        n_cmp++; if (d !== 32'hA000_0000) begin n_err++; $display("FAIL fl_refetch_data: got %h want a0000000", d); end
    endtask

    task automatic test_reset_mid_miss();
        int n; bit ok, hit, rc; logic [31:0] d; logic [26:0] la; int p, fl;
        bus.ADDR = 32'h5000; bus.ADDR_VALID = 1'b1;
        tick();
        bus.ADDR_VALID = 1'b0;
        n = 0;
        while (bus.ADDR_TO_L2_VALID !== 1'b1 && n < 20) begin tick(); n++; end
        n_cmp++; if (bus.ADDR_TO_L2_VALID !== 1'b1) begin n_err++; $display("FAIL rm_l2v: got %b want 1", bus.ADDR_TO_L2_VALID); end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_reset();
        tick();
        tick();
        bus.DATA_FROM_L2 = fill_line(32'h5000 >> 5);
        bus.DATA_FROM_L2_VALID = 1'b1;
        tick();
        bus.DATA_FROM_L2_VALID = 1'b0;
        $display("txn reset_mid_miss addr_out=%h ready=%b", bus.ADDR_OUT, bus.CACHE_READY);
        n_cmp++; if (bus.DATA_VALID !== 1'b0) begin n_err++; $display("FAIL rm_dv: got %b want 0", bus.DATA_VALID); end
        n_cmp++; if (bus.CACHE_READY !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b want 1", bus.CACHE_READY); end
        n_cmp++; if (bus.ADDR_OUT !== 32'h0) begin n_err++; $display("FAIL rm_addr_out: got %h want 0", bus.ADDR_OUT); end
        n_cmp++; if (bus.ADDR_TO_L2_VALID !== 1'b0) begin n_err++; $display("FAIL rm_l2v_after: got %b want 0", bus.ADDR_TO_L2_VALID); end
        void'(m_access(32'h104));
        fetch(32'h104, 2, ok, hit, d, rc, la, p, fl);
        $display("txn after_reset addr=00000104 hit=%0b data=%h", hit, d);
        n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL rm_refetch_hit: got %b want 0", hit); end
        n_cmp++; if (d !== 32'hA000_0001) begin n_err++; $display("FAIL rm_refetch_data: got %h want a0000001", d); end
    endtask

    task automatic test_random();
        bit ok, hit, rc, exp_hit; logic [31:0] d, a, exp_d; logic [26:0] la; int p, fl, n, lo;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                n = 0;
                while (bus.CACHE_READY !== 1'b1 && n < 300) begin tick(); n++; end
                bus.FLUSH = 1'b1;
                tick();
                bus.FLUSH = 1'b0;
                lo = 0; n = 0;
                while (bus.CACHE_READY === 1'b0 && n < 400) begin lo++; tick(); n++; end
                m_flush();
                $display("txn rnd%0d flush walk=%0d", i, lo);
                n_cmp++; if (lo !== SETS) begin n_err++; $display("FAIL rnd_walk%0d: got %0d want %0d", i, lo, SETS); end
            end else begin
                a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
                exp_hit = m_access(a);
                exp_d = line_word(a >> 5, (a >> 2) & 7);
                fetch(a, int'($urandom_range(2, 6)), ok, hit, d, rc, la, p, fl);
                $display("txn rnd%0d addr=%h hit=%0b data=%h", i, a, hit, d);
                n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rnd_ok%0d: got %b want 1", i, ok); end
                n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL rnd_hit%0d: got %b want %b", i, hit, exp_hit); end
                n_cmp++; if (d !== exp_d) begin n_err++; $display("FAIL rnd_data%0d: got %h want %h", i, d, exp_d); end
                if (!exp_hit) begin
                    n_cmp++; if (fl !== 3) begin n_err++; $display("FAIL rnd_lat%0d: got %0d want 3", i, fl); end
                end
            end
        end
`ifdef ICACHE_PERF_EN
        tick();
        n_cmp++; if (bus.HIT_COUNT !== m_hits) begin n_err++; $display("FAIL rnd_hitcnt: got %0d want %0d", bus.HIT_COUNT, m_hits); end
        n_cmp++; if (bus.MISS_COUNT !== m_misses) begin n_err++; $display("FAIL rnd_misscnt: got %0d want %0d", bus.MISS_COUNT, m_misses); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_miss();
        test_back_to_back();
        test_replacement();
        test_flush_miss();
        test_reset_mid_miss();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
